// File: rtl/pc_sequencer.sv
// Next-PC controller: selects sequential, branch, jump-table or return-stack targets,
// raises a one-cycle flush after each redirect and halts on stack faults.
module pc_sequencer #(
    parameter int PC_W     = 8,
    parameter int PC_STEP  = 2,
    parameter int TBL_N    = 16,
    parameter int STK_D    = 4,
    parameter int RESET_PC = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     stall,
    input  logic                     br_taken,
    input  logic [PC_W-1:0]          br_target,
    input  logic                     jt_req,
    input  logic                     call,
    input  logic                     ret,
    input  logic [$clog2(TBL_N)-1:0] jt_idx,
    input  logic                     tbl_we,
    input  logic [$clog2(TBL_N)-1:0] tbl_waddr,
    input  logic [PC_W-1:0]          tbl_wdata,
    output logic [PC_W-1:0]          pc,
    output logic                     flush,
    output logic                     fault,
    output logic                     stk_ovf,
    output logic                     stk_unf
);

    localparam int SP_W = $clog2(STK_D + 1);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_FLUSH,
        ST_FAULT
    } state_e;

    state_e            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic              flush_q, flush_d;
    logic              fault_q;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;
    logic [SP_W-1:0]   sp_q, sp_d;
    logic [PC_W-1:0]   stk_q [STK_D];
    logic [PC_W-1:0]   tbl_q [TBL_N];
    logic              push;
    logic [PC_W-1:0]   pcInc;
    logic [PC_W-1:0]   stkTop;
    logic [PC_W-1:0]   tblRd;

    assign pcInc = pc_q + PC_W'(PC_STEP);
    // Table reads see the registered contents, so a same-cycle write returns the old entry.
    assign tblRd = tbl_q[jt_idx];

    always_comb begin
        stkTop = '0;
        for (int i = 0; i < STK_D; i++) begin
            if (sp_q == SP_W'(i + 1)) stkTop = stk_q[i];
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        flush_d = flush_q;
        sp_d    = sp_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        push    = 1'b0;
        if (!stall) begin
            case (state_q)
                ST_RUN: begin
                    flush_d = 1'b1;
                    state_d = ST_FLUSH;
                    if (ret) begin
                        if (sp_q != '0) begin
                            pc_d = stkTop;
                            sp_d = sp_q - SP_W'(1);
                        end else begin
                            unf_d   = 1'b1;
                            flush_d = 1'b0;
                            state_d = ST_FAULT;
                        end
                    end else if (call) begin
                        if (sp_q != SP_W'(STK_D)) begin
                            push = 1'b1;
                            sp_d = sp_q + SP_W'(1);
                            pc_d = tblRd;
                        end else begin
                            ovf_d   = 1'b1;
                            flush_d = 1'b0;
                            state_d = ST_FAULT;
                        end
                    end else if (jt_req) begin
                        pc_d = tblRd;
                    end else if (br_taken) begin
                        pc_d = br_target;
                    end else begin
                        pc_d    = pcInc;
                        flush_d = 1'b0;
                        state_d = ST_RUN;
                    end
                end
                // Requests arriving here belong to the squashed instruction and are dropped.
                ST_FLUSH: begin
                    pc_d    = pcInc;
                    flush_d = 1'b0;
                    state_d = ST_RUN;
                end
                ST_FAULT: begin
                    state_d = ST_FAULT;
                end
                default: begin
                    state_d = ST_FAULT;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_RUN;
            pc_q    <= PC_W'(RESET_PC);
            flush_q <= 1'b0;
            fault_q <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            sp_q    <= '0;
            for (int i = 0; i < STK_D; i++) stk_q[i] <= '0;
            for (int i = 0; i < TBL_N; i++) tbl_q[i] <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            flush_q <= flush_d;
            fault_q <= (state_d == ST_FAULT);
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
            sp_q    <= sp_d;
            for (int i = 0; i < STK_D; i++) begin
                if (push && sp_q == SP_W'(i)) stk_q[i] <= pcInc;
            end
            if (tbl_we) tbl_q[tbl_waddr] <= tbl_wdata;
        end
    end

    assign pc      = pc_q;
    assign flush   = flush_q;
    assign fault   = fault_q;
    assign stk_ovf = ovf_q;
    assign stk_unf = unf_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Testbench for pc_sequencer: directed vector table followed by randomized traffic
// checked against a queue-based behavioural model.
module tb_pc_sequencer;

    typedef struct {
        logic       rstN;
        logic       stall;
        logic       br;
        logic [7:0] tgt;
        logic       jt;
        logic       call;
        logic       ret;
        logic [3:0] idx;
        logic       we;
        logic [3:0] waddr;
        logic [7:0] wdata;
        logic [7:0] ePc;
        logic       eFlush;
        logic       eFault;
        logic       eOvf;
        logic       eUnf;
    } vec_t;

    logic       clk;
    logic       rst;
    logic       stall;
    logic       br_taken;
    logic [7:0] br_target;
    logic       jt_req;
    logic       call;
    logic       ret;
    logic [3:0] jt_idx;
    logic       tbl_we;
    logic [3:0] tbl_waddr;
    logic [7:0] tbl_wdata;
    logic [7:0] pc;
    logic       flush;
    logic       fault;
    logic       stk_ovf;
    logic       stk_unf;

    int errors = 0;
    int checks = 0;

    int mPc;
    bit mSquash;
    bit mHalted;
    bit mOvf;
    bit mUnf;
    int mStack[$];
    int mTbl[16];

    vec_t vecs[$];

    pc_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .stall     (stall),
        .br_taken  (br_taken),
        .br_target (br_target),
        .jt_req    (jt_req),
        .call      (call),
        .ret       (ret),
        .jt_idx    (jt_idx),
        .tbl_we    (tbl_we),
        .tbl_waddr (tbl_waddr),
        .tbl_wdata (tbl_wdata),
        .pc        (pc),
        .flush     (flush),
        .fault     (fault),
        .stk_ovf   (stk_ovf),
        .stk_unf   (stk_unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input int r, input int s, input int b, input int tg,
                                input int j, input int c, input int rt, input int ix,
                                input int w, input int wa, input int wd,
                                input int p, input int fl, input int fa, input int ov, input int un);
        vec_t v;
        v.rstN = 1'(r);   v.stall = 1'(s);  v.br = 1'(b);     v.tgt = 8'(tg);
        v.jt = 1'(j);     v.call = 1'(c);   v.ret = 1'(rt);   v.idx = 4'(ix);
        v.we = 1'(w);     v.waddr = 4'(wa); v.wdata = 8'(wd);
        v.ePc = 8'(p);    v.eFlush = 1'(fl); v.eFault = 1'(fa);
        v.eOvf = 1'(ov);  v.eUnf = 1'(un);
        return v;
    endfunction

    task automatic applyStimulus(input vec_t v);
        rst       = v.rstN;
        stall     = v.stall;
        br_taken  = v.br;
        br_target = v.tgt;
        jt_req    = v.jt;
        call      = v.call;
        ret       = v.ret;
        jt_idx    = v.idx;
        tbl_we    = v.we;
        tbl_waddr = v.waddr;
        tbl_wdata = v.wdata;
    endtask

    task automatic checkField(input string name, input int n, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("[TB] FAIL %s #%0d: got %0d, expected %0d", name, n, got, want);
        end
    endtask

    task automatic checkOutput(input string tag, input int n, input int ePc, input int eFl,
                               input int eFa, input int eOv, input int eUn);
        checkField({tag, ".pc"}, n, int'(pc), ePc);
        checkField({tag, ".flush"}, n, int'(flush), eFl);
        checkField({tag, ".fault"}, n, int'(fault), eFa);
        checkField({tag, ".stk_ovf"}, n, int'(stk_ovf), eOv);
        checkField({tag, ".stk_unf"}, n, int'(stk_unf), eUn);
    endtask

    // Reference model: the table lookup happens before the same-cycle write lands.
    task automatic modelStep(input vec_t v);
        int look;
        look = mTbl[v.idx];
        if (!v.rstN) begin
            mPc = 0; mSquash = 0; mHalted = 0; mOvf = 0; mUnf = 0;
            mStack.delete();
            foreach (mTbl[i]) mTbl[i] = 0;
        end else begin
            if (!v.stall && !mHalted) begin
                if (mSquash) begin
                    mPc = (mPc + 2) % 256;
                    mSquash = 0;
                end else if (v.ret) begin
                    if (mStack.size() > 0) begin
                        mPc = mStack.pop_back();
                        mSquash = 1;
                    end else begin
                        mUnf = 1;
                        mHalted = 1;
                    end
                end else if (v.call) begin
                    if (mStack.size() < 4) begin
                        mStack.push_back((mPc + 2) % 256);
                        mPc = look;
                        mSquash = 1;
                    end else begin
                        mOvf = 1;
                        mHalted = 1;
                    end
                end else if (v.jt) begin
                    mPc = look;
                    mSquash = 1;
                end else if (v.br) begin
                    mPc = int'(v.tgt);
                    mSquash = 1;
                end else begin
                    mPc = (mPc + 2) % 256;
                end
            end
            if (v.we) mTbl[v.waddr] = int'(v.wdata);
        end
    endtask

    initial begin
        vec_t r;
        // r  s  b  tgt  j  c  rt ix  we wa wd   pc fl fa ov un
        vecs.push_back(mk(0, 1, 1, 77,  0, 0, 0, 0,  0, 0, 0,    0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0,   0, 0, 0, 0,  0, 0, 0,    2, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0,   0, 0, 0, 0,  0, 0, 0,    4, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0,   0, 0, 0, 0,  0, 0, 0,    6, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0,   0, 0, 0, 0,  0, 0, 0,    8, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0,   0, 0, 0, 0,  1, 5, 252,  10, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0,   1, 0, 0, 5,  0, 0, 0,    252, 1, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0,   0, 0, 0, 0,  0, 0, 0,    254, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0,   0, 0, 0, 0,  0, 0, 0,    0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0,   1, 0, 0, 3,  1, 3, 150,  0, 1, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0,   0, 0, 0, 0,  0, 0, 0,    2, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0,   1, 0, 0, 3,  0, 0, 0,    150, 1, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0,   0, 0, 0, 0,  0, 0, 0,    152, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0,   0, 0, 0, 0,  1, 6, 8,    154, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0,   1, 0, 0, 6,  0, 0, 0,    8, 1, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0,   0, 0, 0, 0,  0, 0, 0,    10, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 1, 130, 0, 0, 0, 0,  0, 0, 0,    130, 1, 0, 0, 0));
        vecs.push_back(mk(1, 0, 1, 8,   0, 0, 0, 0,  0, 0, 0,    132, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0,   0, 0, 0, 0,  0, 0, 0,    134, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0,   0, 0, 0, 0,  1, 1, 48,   136, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0,   0, 0, 0, 0,  1, 7, 18,   138, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0,   1, 0, 0, 7,  0, 0, 0,    18, 1, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0,   0, 0, 0, 0,  0, 0, 0,    20, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0,   0, 1, 0, 1,  0, 0, 0,    48, 1, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0,   0, 0, 0, 0,  0, 0, 0,    50, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0,   0, 0, 0, 0,  0, 0, 0,    52, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0,   0, 0, 1, 0,  0, 0, 0,    22, 1, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0,   0, 0, 0, 0,  0, 0, 0,    24, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0,   0, 1, 0, 1,  0, 0, 0,    48, 1, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0,   0, 0, 0, 0,  0, 0, 0,    50, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0,   0, 1, 1, 1,  0, 0, 0,    26, 1, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0,   0, 0, 0, 0,  0, 0, 0,    28, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0,   0, 0, 1, 0,  0, 0, 0,    28, 0, 1, 0, 1));
        vecs.push_back(mk(1, 0, 1, 100, 0, 0, 0, 0,  0, 0, 0,    28, 0, 1, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0,   0, 0, 0, 0,  0, 0, 0,    0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0,   0, 1, 0, 0,  0, 0, 0,    0, 1, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0,   0, 0, 0, 0,  0, 0, 0,    2, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0,   0, 1, 0, 0,  0, 0, 0,    0, 1, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0,   0, 0, 0, 0,  0, 0, 0,    2, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0,   0, 1, 0, 0,  0, 0, 0,    0, 1, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0,   0, 0, 0, 0,  0, 0, 0,    2, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0,   0, 1, 0, 0,  0, 0, 0,    0, 1, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0,   0, 0, 0, 0,  0, 0, 0,    2, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0,   0, 1, 0, 0,  0, 0, 0,    2, 0, 1, 1, 0));
        vecs.push_back(mk(1, 0, 1, 60,  0, 0, 0, 0,  0, 0, 0,    2, 0, 1, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0,   0, 0, 0, 0,  0, 0, 0,    0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0,   0, 0, 0, 0,  1, 2, 40,   2, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0,   1, 0, 0, 2,  0, 0, 0,    40, 1, 0, 0, 0));
        vecs.push_back(mk(1, 1, 0, 0,   0, 0, 0, 0,  1, 9, 99,   40, 1, 0, 0, 0));
        vecs.push_back(mk(1, 1, 1, 5,   0, 0, 0, 0,  0, 0, 0,    40, 1, 0, 0, 0));
        vecs.push_back(mk(1, 1, 0, 0,   0, 0, 0, 0,  0, 0, 0,    40, 1, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0,   0, 0, 0, 0,  0, 0, 0,    42, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0,   1, 0, 0, 9,  0, 0, 0,    99, 1, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0,   0, 0, 0, 0,  0, 0, 0,    101, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0,   0, 0, 1, 0,  0, 0, 0,    0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0,   0, 0, 1, 0,  0, 0, 0,    0, 0, 1, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0,   0, 0, 0, 0,  0, 0, 0,    0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 1, 33,  0, 0, 0, 0,  0, 0, 0,    0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0,   0, 0, 0, 0,  0, 0, 0,    2, 0, 0, 0, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            @(posedge clk);
            #1;
            checkOutput("dir", i, int'(vecs[i].ePc), int'(vecs[i].eFlush), int'(vecs[i].eFault),
                        int'(vecs[i].eOvf), int'(vecs[i].eUnf));
        end

        r = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(r);
        modelStep(r);
        @(posedge clk);
        #1;
        checkOutput("rndrst", 0, mPc, int'(mSquash), int'(mHalted), int'(mOvf), int'(mUnf));

        for (int n = 0; n < 3000; n++) begin
            r.rstN  = mHalted ? ($urandom_range(0, 4) != 0) : ($urandom_range(0, 79) != 0);
            r.stall = ($urandom_range(0, 5) == 0);
            r.br    = ($urandom_range(0, 4) == 0);
            r.tgt   = 8'($urandom);
            r.jt    = ($urandom_range(0, 7) == 0);
            r.call  = ($urandom_range(0, 8) == 0);
            r.ret   = ($urandom_range(0, 11) == 0);
            r.idx   = 4'($urandom);
            r.we    = ($urandom_range(0, 3) == 0);
            r.waddr = 4'($urandom);
            r.wdata = 8'($urandom);
            applyStimulus(r);
            modelStep(r);
            @(posedge clk);
            #1;
            checkOutput("rnd", n, mPc, int'(mSquash), int'(mHalted), int'(mOvf), int'(mUnf));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Next-PC controller for the single-cycle core's program counter register. Each cycle it selects the next fetch address from four sources: sequential increment, branch target, a software-programmable jump-target table, or a return-address stack. It also raises a one-cycle flush after every redirect and stops the core on stack faults. It sits between the decode/branch logic and instruction-memory addressing, and replaces fixed per-label jump constants with table entries written at boot.

Parameters:
PC_W, 8, program counter width in bits
PC_STEP, 2, sequential increment per instruction
TBL_N, 16, jump-table entries (index width = log2(TBL_N))
STK_D, 4, return-address stack depth
RESET_PC, 0, PC value loaded on reset

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous reset, active-low (rst=0 at a rising edge resets)
stall  input  1  hold the PC and all state this cycle
br_taken  input  1  conditional branch resolved taken
br_target  input  PC_W  branch destination
jt_req  input  1  jump to table entry jt_idx
call  input  1  push return address, then jump to table entry jt_idx
ret  input  1  pop return address and jump to it
jt_idx  input  log2(TBL_N)  table index for jt_req/call
tbl_we  input  1  jump-table write enable
tbl_waddr  input  log2(TBL_N)  jump-table write index
tbl_wdata  input  PC_W  jump-table write data
pc  output  PC_W  current fetch address (registered)
flush  output  1  squash the instruction fetched at the old PC (registered)
fault  output  1  sequencer halted (registered)
stk_ovf  output  1  sticky: call issued with stack full
stk_unf  output  1  sticky: ret issued with stack empty

Behaviour:
- Reset (rst=0 at a rising edge): pc=RESET_PC; flush=0; fault=0; stk_ovf=0; stk_unf=0; stack pointer=0; all table entries=0; state=RUN. Reset overrides stall and all other inputs. Reset mid-operation discards in-flight redirects.
- States:
  - RUN: normal operation.
  - FLUSH: one cycle after a redirect.
  - FAULT: terminal until reset.
- Stall: when stall=1 (not in reset), pc, state, stack and flush hold their values. Table writes still occur; they are independent of stall and state.
- RUN, no stall. Select by priority ret > call > jt_req > br_taken > sequential:
  - ret, stack non-empty: pc <= top of stack; pop; flush=1; -> FLUSH.
  - ret, stack empty: stk_unf=1; fault=1; pc holds; -> FAULT.
  - call, stack not full: push (pc+PC_STEP) mod 2^PC_W; pc <= table[jt_idx]; flush=1; -> FLUSH.
  - call, stack full: stk_ovf=1; fault=1; pc holds; -> FAULT. No push occurs.
  - jt_req: pc <= table[jt_idx]; flush=1; -> FLUSH.
  - br_taken: pc <= br_target; flush=1; -> FLUSH.
  - none: pc <= (pc+PC_STEP) mod 2^PC_W; flush=0. Example with PC_W=8, PC_STEP=2: 254 -> 0.
- FLUSH, no stall: all redirect inputs are ignored (they belong to the squashed instruction). pc <= pc+PC_STEP; flush=0; -> RUN. Lower-priority requests are dropped, not queued.
- FAULT: pc, stack and flush hold; fault=1; redirect inputs ignored; only reset exits.
- Redirect latency: a request sampled at edge N produces the new pc and flush=1 after edge N. Sequential fetch resumes after edge N+1.
- Jump table:
  - Synchronous write on tbl_we.
  - A lookup in the same cycle as a write to the same index returns the old value (read-before-write).
  - The new value is visible from the next cycle.
- Stack: LIFO of STK_D entries. A simultaneous call+ret resolves as ret only. stk_ovf and stk_unf clear only on reset.

Test Plan:
- Reset with stall=1 and br_taken=1 -> pc=0, flush=0, fault=0 after the edge. Then 4 idle cycles -> pc=2,4,6,8. Preload pc=254, idle -> pc=0 (wrap).
- Write table[3]=150 (tbl_we). In the same cycle, jt_req with jt_idx=3 -> pc=0 (old value), flush=1. Next jt_req idx 3 after FLUSH -> pc=150.
- Branch redirect: pc=10, br_taken=1, br_target=130 -> pc=130, flush=1. Next cycle br_taken=1, br_target=8 -> ignored, pc=132, flush=0.
- Call/return: table[1]=48, pc=20, call idx 1 -> pc=48. Run 2 cycles (50, 52), ret -> pc=22, flush=1. ret with call also asserted -> only the pop occurs.
- Five nested calls with STK_D=4 -> 5th sets stk_ovf=1, fault=1, pc frozen. Further branches are ignored until rst=0. Separately, ret at reset -> stk_unf=1, fault=1.
- Stall held 3 cycles during FLUSH -> pc, flush=1 and state held. tbl_we during stall updates the table. Release -> pc+2, flush=0.
